// File: rtl/crc_axi_stream_checker.sv
// Frame checker for an AXI-Stream Ethernet-style byte stream: CRC-32 residue,
// length/tkeep and tuser checks, with a held result and good/bad frame counters.
module crc_axi_stream_checker #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_axi_stream_tvalid,
    output logic                  s_axi_stream_tready,
    input  logic                  s_axi_stream_tlast,
    input  logic                  s_axi_stream_tuser,
    input  logic [DATA_WIDTH-1:0] s_axi_stream_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axi_stream_tkeep,
    output logic                  m_check_valid,
    input  logic                  m_check_ready,
    output logic                  m_check_ok,
    output logic                  m_check_crc_err,
    output logic                  m_check_len_err,
    output logic                  m_check_user_err,
    output logic [15:0]           m_check_byte_count,
    output logic [31:0]           good_frame_count,
    output logic [31:0]           bad_frame_count
);

    typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

    localparam logic [31:0]           CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0]           CRC_POLY = 32'hEDB8_8320;
    localparam logic [31:0]           RESIDUE  = 32'hDEBB_20E3;
    localparam logic [KEEP_WIDTH-1:0] KEEP_ONE = KEEP_WIDTH'(1);

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int k = 0; k < 8; k++)
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        user_q, user_d;
    logic        keep_err_q, keep_err_d;
    logic [31:0] good_q, good_d;
    logic [31:0] bad_q, bad_d;

    logic        beat_acc;
    logic        keep_ok;
    logic [31:0] base_crc, beat_crc;
    logic [15:0] base_cnt;
    logic [16:0] cnt_sum;
    logic        base_user, base_keep_err;
    logic        crc_bad, len_bad, frame_ok;

    always_comb begin
        beat_acc = s_axi_stream_tvalid && s_axi_stream_tready;

        // The first beat taken in IDLE starts a fresh frame from init values.
        base_crc      = (state_q == IDLE) ? CRC_INIT : crc_q;
        base_cnt      = (state_q == IDLE) ? 16'd0    : cnt_q;
        base_user     = (state_q == IDLE) ? 1'b0     : user_q;
        base_keep_err = (state_q == IDLE) ? 1'b0     : keep_err_q;

        beat_crc = base_crc;
        cnt_sum  = {1'b0, base_cnt};
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (s_axi_stream_tkeep[i])
                beat_crc = crc_byte(beat_crc, s_axi_stream_tdata[8*i +: 8]);
            cnt_sum = cnt_sum + {16'd0, s_axi_stream_tkeep[i]};
        end

        // Last beat must be a nonzero run of ones starting at bit 0.
        keep_ok = s_axi_stream_tlast
                ? ((s_axi_stream_tkeep != '0) &&
                   ((s_axi_stream_tkeep & (s_axi_stream_tkeep + KEEP_ONE)) == '0))
                : (&s_axi_stream_tkeep);

        crc_bad  = (crc_q != RESIDUE);
        len_bad  = keep_err_q || (cnt_q < 16'd5);
        frame_ok = !(crc_bad || len_bad || user_q);

        state_d    = state_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        user_d     = user_q;
        keep_err_d = keep_err_q;
        good_d     = good_q;
        bad_d      = bad_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (beat_acc) begin
                    crc_d      = beat_crc;
                    cnt_d      = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
                    user_d     = base_user | s_axi_stream_tuser;
                    keep_err_d = base_keep_err | !keep_ok;
                    state_d    = s_axi_stream_tlast ? RESULT : ACCUM;
                end
            end
            RESULT: begin
                if (m_check_ready) begin
                    state_d = IDLE;
                    if (frame_ok) good_d = good_q + 32'd1;
                    else          bad_d  = bad_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            crc_q      <= CRC_INIT;
            cnt_q      <= 16'd0;
            user_q     <= 1'b0;
            keep_err_q <= 1'b0;
            good_q     <= 32'd0;
            bad_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            cnt_q      <= cnt_d;
            user_q     <= user_d;
            keep_err_q <= keep_err_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
        end
    end

    // Result fields are held frame state, so they stay stable under backpressure.
    assign s_axi_stream_tready = !reset && (state_q != RESULT);
    assign m_check_valid       = (state_q == RESULT);
    assign m_check_ok          = m_check_valid && frame_ok;
    assign m_check_crc_err     = m_check_valid && crc_bad;
    assign m_check_len_err     = m_check_valid && len_bad;
    assign m_check_user_err    = m_check_valid && user_q;
    assign m_check_byte_count  = cnt_q;
    assign good_frame_count    = good_q;
    assign bad_frame_count     = bad_q;

endmodule

// File: tb/tb_crc_axi_stream_checker.sv
// Randomized and directed bench for crc_axi_stream_checker against a frame-level
// model: FCS must equal the CRC-32 of the preceding bytes.
module tb_crc_axi_stream_checker;

    localparam int DW = 64;
    localparam int KW = DW / 8;

    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          reset;
    logic          s_axi_stream_tvalid;
    logic          s_axi_stream_tready;
    logic          s_axi_stream_tlast;
    logic          s_axi_stream_tuser;
    logic [DW-1:0] s_axi_stream_tdata;
    logic [KW-1:0] s_axi_stream_tkeep;
    logic          m_check_valid;
    logic          m_check_ready;
    logic          m_check_ok;
    logic          m_check_crc_err;
    logic          m_check_len_err;
    logic          m_check_user_err;
    logic [15:0]   m_check_byte_count;
    logic [31:0]   good_frame_count;
    logic [31:0]   bad_frame_count;

    crc_axi_stream_checker #(.DATA_WIDTH(DW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .s_axi_stream_tvalid (s_axi_stream_tvalid),
        .s_axi_stream_tready (s_axi_stream_tready),
        .s_axi_stream_tlast  (s_axi_stream_tlast),
        .s_axi_stream_tuser  (s_axi_stream_tuser),
        .s_axi_stream_tdata  (s_axi_stream_tdata),
        .s_axi_stream_tkeep  (s_axi_stream_tkeep),
        .m_check_valid       (m_check_valid),
        .m_check_ready       (m_check_ready),
        .m_check_ok          (m_check_ok),
        .m_check_crc_err     (m_check_crc_err),
        .m_check_len_err     (m_check_len_err),
        .m_check_user_err    (m_check_user_err),
        .m_check_byte_count  (m_check_byte_count),
        .good_frame_count    (good_frame_count),
        .bad_frame_count     (bad_frame_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_good = 0;
    int exp_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Plain CRC-32/IEEE of a byte string (final value, complemented).
    function automatic logic [31:0] crc32(input bq_t b, input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic check_fields(input string tag, input logic e_ok, input logic e_crc, input logic chk_crc,
                                input logic e_len, input logic e_user, input int e_cnt);
        chk({tag, ".valid"}, m_check_valid, 1'b1);
        chk({tag, ".ok"}, m_check_ok, e_ok);
        if (chk_crc) chk({tag, ".crc_err"}, m_check_crc_err, e_crc);
        chk({tag, ".len_err"}, m_check_len_err, e_len);
        chk({tag, ".user_err"}, m_check_user_err, e_user);
        chk({tag, ".byte_count"}, m_check_byte_count, 64'(e_cnt));
    endtask

    // Sends one frame, checks the result (optionally under backpressure), consumes it.
    task automatic run_frame(input string tag, input bq_t fb, input logic [31:0] umask,
                             input int bad_keep_beat, input int hold);
        int n, nb, rem, t, e_cnt;
        logic e_user, e_len, e_crc, e_ok, chk_crc;
        logic [31:0] fcs;
        n  = fb.size();
        nb = (n + KW - 1) / KW;
        e_user = 1'b0;
        for (int k = 0; k < nb; k++) e_user |= umask[k];
        e_cnt = (bad_keep_beat >= 0) ? n - 1 : n;
        e_len = (n < 5) || (bad_keep_beat >= 0);
        chk_crc = (n >= 5) && (bad_keep_beat < 0);
        fcs = (n >= 4) ? {fb[n-1], fb[n-2], fb[n-3], fb[n-4]} : 32'd0;
        e_crc = !((n >= 4) && (fcs == crc32(fb, n - 4)));
        e_ok = !(e_len || e_user || (chk_crc ? e_crc : 1'b1));

        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            rem = n - k * KW;
            s_axi_stream_tvalid = 1'b1;
            s_axi_stream_tlast  = (k == nb - 1);
            s_axi_stream_tuser  = umask[k];
            s_axi_stream_tdata  = '0;
            for (int i = 0; i < KW; i++)
                if (i < rem) s_axi_stream_tdata[8*i +: 8] = fb[k*KW + i];
            s_axi_stream_tkeep = (rem >= KW) ? '1 : KW'((1 << rem) - 1);
            if (k == bad_keep_beat && k != nb - 1) s_axi_stream_tkeep = 8'h7F;
            t = 0;
            while (!s_axi_stream_tready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) chk({tag, ".tready_timeout"}, 1'b0, 1'b1);
            @(posedge clk);
        end
        #1;
        s_axi_stream_tvalid = 1'b0;
        s_axi_stream_tlast  = 1'b0;
        s_axi_stream_tuser  = 1'b0;
        check_fields(tag, e_ok, e_crc, chk_crc, e_len, e_user, e_cnt);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            s_axi_stream_tvalid = 1'b1;
            s_axi_stream_tlast  = 1'b1;
            s_axi_stream_tkeep  = '1;
            s_axi_stream_tdata  = {$urandom, $urandom};
            chk({tag, ".hold_tready"}, s_axi_stream_tready, 1'b0);
            check_fields({tag, ".hold"}, e_ok, e_crc, chk_crc, e_len, e_user, e_cnt);
        end

        @(negedge clk);
        s_axi_stream_tvalid = 1'b0;
        s_axi_stream_tlast  = 1'b0;
        m_check_ready = 1'b1;
        @(posedge clk);
        #1;
        m_check_ready = 1'b0;
        if (e_ok) exp_good++;
        else      exp_bad++;
        chk({tag, ".valid_after"}, m_check_valid, 1'b0);
        chk({tag, ".tready_after"}, s_axi_stream_tready, 1'b1);
        chk({tag, ".good_cnt"}, good_frame_count, 64'(exp_good));
        chk({tag, ".bad_cnt"}, bad_frame_count, 64'(exp_bad));
    endtask

    function automatic bq_t good_ref();
        bq_t q;
        q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
        return q;
    endfunction

    initial begin
        bq_t fb;
        logic [31:0] c;
        int n;
        reset = 1'b1;
        s_axi_stream_tvalid = 1'b0;
        s_axi_stream_tlast  = 1'b0;
        s_axi_stream_tuser  = 1'b0;
        s_axi_stream_tdata  = '0;
        s_axi_stream_tkeep  = '0;
        m_check_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.tready", s_axi_stream_tready, 1'b0);
        chk("rst.valid", m_check_valid, 1'b0);
        chk("rst.good", good_frame_count, 0);
        chk("rst.bad", bad_frame_count, 0);
        chk("rst.byte_count", m_check_byte_count, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.tready_rel", s_axi_stream_tready, 1'b1);

        fb = good_ref();
        run_frame("good", fb, 32'd0, -1, 0);
        chk("good.cnt_const", good_frame_count, 1);
        fb[0] = 8'h30;
        run_frame("badcrc", fb, 32'd0, -1, 0);
        chk("badcrc.cnt_const", bad_frame_count, 1);
        fb = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_frame("short4", fb, 32'd0, -1, 0);
        fb = good_ref();
        run_frame("user", fb, 32'd1, -1, 0);
        run_frame("badkeep", fb, 32'd0, 0, 0);
        run_frame("bp1", fb, 32'd0, -1, 10);
        fb[3] = 8'hAA;
        run_frame("bp2", fb, 32'd0, -1, 0);

        // Reset in the middle of a frame discards it and clears counters.
        @(negedge clk);
        s_axi_stream_tvalid = 1'b1;
        s_axi_stream_tlast  = 1'b0;
        s_axi_stream_tkeep  = '1;
        s_axi_stream_tdata  = {$urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        s_axi_stream_tvalid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst.valid", m_check_valid, 1'b0);
        chk("midrst.tready", s_axi_stream_tready, 1'b0);
        chk("midrst.good", good_frame_count, 0);
        chk("midrst.bad", bad_frame_count, 0);
        chk("midrst.byte_count", m_check_byte_count, 0);
        exp_good = 0;
        exp_bad = 0;
        @(negedge clk);
        reset = 1'b0;
        fb = good_ref();
        run_frame("postrst", fb, 32'd0, -1, 0);

        for (int r = 0; r < 30; r++) begin
            fb = {};
            n = $urandom_range(1, 40);
            if (n >= 5) begin
                for (int i = 0; i < n - 4; i++) fb.push_back(8'($urandom));
                c = crc32(fb, n - 4);
                for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
                if ($urandom_range(0, 2) == 0)
                    fb[$urandom_range(0, n - 1)] ^= 8'($urandom_range(1, 255));
            end else begin
                for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
            end
            run_frame("rand", fb, ($urandom_range(0, 4) == 0) ? 32'($urandom) : 32'd0,
                      -1, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/crc_axi_stream_checker.md
CRC_AXI_STREAM_CHECKER -- requirements
Module: crc_axi_stream_checker

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- DATA_WIDTH, 64, input stream data width in bits; multiple of 8, minimum 32.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width, one bit per byte.
REQ-002 One clock; reset is asynchronous and active-high. Ports, one per line: name, direction, width, meaning:
- clk, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- s_axi_stream_tvalid, input, 1, input beat valid.
- s_axi_stream_tready, output, 1, checker can accept a beat.
- s_axi_stream_tlast, input, 1, final beat of the frame.
- s_axi_stream_tuser, input, 1, upstream error marker; may assert on any beat.
- s_axi_stream_tdata, input, DATA_WIDTH, payload; byte i is tdata[8i+7:8i], byte 0 first on the wire.
- s_axi_stream_tkeep, input, KEEP_WIDTH, byte enables.
- m_check_valid, output, 1, check result valid.
- m_check_ready, input, 1, result consumer ready.
- m_check_ok, output, 1, frame passed every check.
- m_check_crc_err, output, 1, FCS residue mismatch.
- m_check_len_err, output, 1, frame shorter than 5 bytes.
- m_check_user_err, output, 1, tuser seen on any beat of the frame.
- m_check_byte_count, output, 16, frame bytes including FCS; saturates at 0xFFFF.
- good_frame_count, output, 32, frames with ok=1; wraps.
- bad_frame_count, output, 32, frames with ok=0; wraps.

Function
REQ-003 A beat is accepted when s_axi_stream_tvalid and s_axi_stream_tready are both high in the same cycle; a result is consumed when m_check_valid and m_check_ready are both high.
REQ-004 CRC is CRC-32/IEEE 802.3: reflected, polynomial 0x04C11DB7 (reflected 0xEDB88320), initial value 0xFFFFFFFF.
- The CRC runs over every accepted byte, including the 4 trailing FCS bytes.
- All KEEP_WIDTH bytes are processed in one cycle.
REQ-005 Check rule: crc_err=1 when the CRC register, before final XOR, is not 0xDEBB20E3 after the last byte.
REQ-006 tkeep rules:
- Non-last beats: tkeep is all ones.
- Last beat: tkeep is contiguous from bit 0 and nonzero.
- Any violation sets len_err for the frame.
- Bytes with tkeep=0 are never fed to the CRC.
REQ-007 State machine: IDLE, ACCUM, RESULT.
- IDLE -> ACCUM on an accepted non-last beat.
- IDLE -> RESULT on an accepted last beat (single-beat frame).
- ACCUM -> RESULT on an accepted last beat.
- RESULT -> IDLE on result consumption.
REQ-008 s_axi_stream_tready = (state != RESULT); it does not depend on tvalid, tlast or tuser.
REQ-009 The first accepted beat in IDLE restarts the CRC from 0xFFFFFFFF, clears the byte counter and clears the user-error flag.
REQ-010 m_check_valid rises in the cycle after the last beat is accepted (latency 1).
- All m_check_* fields stay stable while valid is high and ready is low.
REQ-011 ok = !(crc_err | len_err | user_err); the error flags are independent and may assert together.
REQ-012 The counters update in the cycle the result is consumed, not when it is produced.
- ok=1 increments good_frame_count; ok=0 increments bad_frame_count; both wrap modulo 2^32.
REQ-013 Back-to-back frames: consuming a result in the same cycle the last beat was accepted is impossible, because tready is 0 in RESULT.
- After consumption, tready is 1 in the next cycle.
- Minimum frame cadence is one beat per frame plus one cycle.
REQ-014 m_check_byte_count sums popcount(tkeep) over the frame and holds at 0xFFFF with no wrap.

Reset
REQ-015 Asserting reset at any time, including mid-frame or with a result pending, immediately forces:
- state=IDLE, m_check_valid=0, s_axi_stream_tready=0 while reset is high.
- CRC register=0xFFFFFFFF.
- Byte count, flags and both frame counters = 0.
- A partial frame is discarded and not counted.
REQ-016 After reset deasserts, s_axi_stream_tready=1 on the first clock edge.

Verification
REQ-017 The bench covers these directed scenarios:
- Good frame: ASCII "123456789" + FCS bytes 0x26,0x39,0xF4,0xCB (13 bytes; beat0 keep 0xFF, beat1 keep 0x1F tlast) -> one cycle later valid=1, ok=1, byte_count=13; after consumption good_frame_count=1.
- Same frame with byte 0 changed to 0x30 -> crc_err=1, ok=0, bad_frame_count=1.
- 4-byte single-beat frame, keep 0x0F tlast -> len_err=1; the crc_err value is not checked.
- Good frame with tuser=1 on beat 0 only -> user_err=1, crc_err=0, ok=0.
- Backpressure: m_check_ready held low 10 cycles after tlast -> tready=0 and fields stable throughout; a second frame is accepted only after consumption and both results are correct.
- Reset asserted mid-frame after beat 0 -> valid=0 and counters=0; a subsequent good frame yields ok=1.
